// File: rtl/apu_rr_alloc_if.sv
// Core/APU handshake bundle for the round-robin APU allocator.
// The slave modport is the allocator side; the master modport is the core/APU side.
interface apu_rr_alloc_if #(
  parameter int unsigned NB_CORES = 4,
  parameter int unsigned NB_APUS  = 2
);
  localparam int unsigned APU_ID_W = ($clog2(NB_APUS) > 1) ? $clog2(NB_APUS) : 1;

  logic [NB_CORES-1:0]               req_i;
  logic [NB_CORES-1:0]               gnt_o;
  logic [NB_CORES-1:0][APU_ID_W-1:0] routing_addr_o;
  logic [NB_APUS-1:0]                apu_req_o;
  logic [NB_APUS-1:0]                apu_gnt_i;
  logic [NB_APUS-1:0]                apu_rvalid_i;
  logic [NB_CORES-1:0]               core_rvalid_o;
  logic [NB_APUS-1:0]                apu_busy_o;
  logic                              err_o;

  modport slave (
    input  req_i, apu_gnt_i, apu_rvalid_i,
    output gnt_o, routing_addr_o, apu_req_o, core_rvalid_o, apu_busy_o, err_o
  );

  modport master (
    output req_i, apu_gnt_i, apu_rvalid_i,
    input  gnt_o, routing_addr_o, apu_req_o, core_rvalid_o, apu_busy_o, err_o
  );
endinterface

// File: rtl/apu_rr_alloc.sv
// Round-robin allocator sharing NB_APUS APUs among NB_CORES cores, one outstanding
// operation per core, with results routed back to the owning core.
module apu_rr_alloc #(
  parameter int unsigned NB_CORES = 4,
  parameter int unsigned NB_APUS  = 2
) (
  input  logic          clk,
  input  logic          rst,
  apu_rr_alloc_if.slave bus
);
  localparam int unsigned CORE_ID_W = ($clog2(NB_CORES) > 1) ? $clog2(NB_CORES) : 1;
  localparam int unsigned APU_ID_W  = ($clog2(NB_APUS) > 1) ? $clog2(NB_APUS) : 1;
  localparam int unsigned IDX_W     = CORE_ID_W + 1;

  logic [NB_APUS-1:0]                 busy, busy_d;
  logic [NB_APUS-1:0][CORE_ID_W-1:0]  owner, owner_d;
  logic [NB_CORES-1:0]                pending, pending_d;
  logic [CORE_ID_W-1:0]               ptr, ptr_d;
  logic                               err, err_d;

  logic [NB_CORES-1:0]                gnt, core_rvalid;
  logic [NB_CORES-1:0][APU_ID_W-1:0]  routing;
  logic [NB_APUS-1:0]                 apu_req, free;
  logic [IDX_W-1:0]                   idx;
  logic [CORE_ID_W-1:0]               c;
  logic                               found;

  // Assignment scan, handshake acceptance, result routing and next state.
  always_comb begin
    gnt         = '0;
    core_rvalid = '0;
    routing     = '0;
    apu_req     = '0;
    free        = ~busy;
    idx         = '0;
    c           = '0;
    found       = 1'b0;
    busy_d      = busy;
    owner_d     = owner;
    pending_d   = pending;
    ptr_d       = ptr;
    err_d       = 1'b0;

    for (int unsigned k = 0; k < NB_CORES; k++) begin
      idx = {1'b0, ptr} + IDX_W'(k);
      if (idx >= IDX_W'(NB_CORES)) idx = idx - IDX_W'(NB_CORES);
      c     = idx[CORE_ID_W-1:0];
      found = 1'b0;
      if (bus.req_i[c] && !pending[c]) begin
        for (int unsigned a = 0; a < NB_APUS; a++) begin
          if (!found && free[a]) begin
            found      = 1'b1;
            free[a]    = 1'b0;
            apu_req[a] = 1'b1;
            routing[c] = APU_ID_W'(a);
            if (bus.apu_gnt_i[a]) begin
              gnt[c]       = 1'b1;
              busy_d[a]    = 1'b1;
              owner_d[a]   = c;
              pending_d[c] = 1'b1;
              // The last grant in scan order wins, so ptr lands just past it.
              ptr_d = (c == CORE_ID_W'(NB_CORES - 1)) ? '0 : c + CORE_ID_W'(1);
            end
          end
        end
      end
    end

    // A result from an idle APU has no owner to route to and is flagged instead.
    for (int unsigned a = 0; a < NB_APUS; a++) begin
      if (bus.apu_rvalid_i[a]) begin
        if (busy[a]) begin
          core_rvalid[owner[a]] = 1'b1;
          pending_d[owner[a]]   = 1'b0;
          busy_d[a]             = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      owner   <= '0;
      pending <= '0;
      ptr     <= '0;
      err     <= 1'b0;
    end else begin
      busy    <= busy_d;
      owner   <= owner_d;
      pending <= pending_d;
      ptr     <= ptr_d;
      err     <= err_d;
    end
  end

  assign bus.gnt_o          = gnt;
  assign bus.routing_addr_o = routing;
  assign bus.apu_req_o      = apu_req;
  assign bus.core_rvalid_o  = core_rvalid;
  assign bus.apu_busy_o     = busy;
  assign bus.err_o          = err;
endmodule

// File: doc/apu_rr_alloc.md
APU_RR_ALLOC -- requirements
Module: apu_rr_alloc

Interface
REQ-001 SHALL have parameter NB_CORES, default 4, number of requesting cores (>=2).
REQ-002 SHALL have parameter NB_APUS, default 2, number of shared APUs (1..NB_CORES).
REQ-003 SHALL derive localparams CORE_ID_W = max(1,$clog2(NB_CORES)) and APU_ID_W = max(1,$clog2(NB_APUS)).
REQ-004 SHALL use one clock and a synchronous active-high reset (fixed).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_i  input  NB_CORES  per-core operation request.
REQ-008 gnt_o  output  NB_CORES  per-core grant; the operation is accepted this cycle.
REQ-009 routing_addr_o  output  NB_CORES x APU_ID_W  APU index assigned to each core; 0 when unassigned.
REQ-010 apu_req_o  output  NB_APUS  per-APU request toward the APU.
REQ-011 apu_gnt_i  input  NB_APUS  per-APU acceptance.
REQ-012 apu_rvalid_i  input  NB_APUS  per-APU result valid, one cycle per completed operation.
REQ-013 core_rvalid_o  output  NB_CORES  result valid, routed to the owning core.
REQ-014 apu_busy_o  output  NB_APUS  APU holds an outstanding operation.
REQ-015 err_o  output  1  one-cycle pulse on a protocol error.

Function
REQ-016 SHALL hold the state busy[NB_APUS], owner[NB_APUS] (CORE_ID_W), pending[NB_CORES], ptr (CORE_ID_W) and err.
REQ-017 An APU SHALL be free iff busy[a]=0; a busy APU is not free even in the cycle its apu_rvalid_i is high.
REQ-018 A core SHALL be eligible iff req_i[c]=1 and pending[c]=0, so each core has at most one outstanding operation.
REQ-019 Assignment is combinational: scan the eligible cores in order ptr, ptr+1, ..., wrapping modulo NB_CORES; the k-th eligible core (k from 0) gets the k-th free APU in ascending APU index.
REQ-020 Eligible cores beyond the free-APU count SHALL be unassigned: gnt_o=0 and routing_addr_o=0.
REQ-021 apu_req_o[a] SHALL be 1 iff some core is assigned to APU a.
REQ-022 gnt_o[c] SHALL be 1 iff core c is assigned to APU a and apu_gnt_i[a]=1 (zero-latency handshake).
REQ-023 On an accepted handshake the next cycle SHALL have busy[a]=1, owner[a]=c and pending[c]=1.
REQ-024 Assigned but unaccepted (apu_gnt_i=0): no state change; the assignment is recomputed every cycle.
REQ-025 On apu_rvalid_i[a]=1 with busy[a]=1: core_rvalid_o[owner[a]]=1 in the same cycle; next cycle busy[a]=0 and pending[owner[a]]=0.
REQ-026 On apu_rvalid_i[a]=1 with busy[a]=0: no core_rvalid_o; err_o=1 in the next cycle only.
REQ-027 core_rvalid_o SHALL never have two APUs driving the same core, which REQ-018 guarantees.
REQ-028 ptr update: if any gnt_o bit is set, ptr <= (index of the last granted core in scan order + 1) mod NB_CORES; otherwise hold.
REQ-029 apu_busy_o SHALL equal busy; all other outputs are combinational from state and inputs, except err_o, which is registered.

Reset
REQ-030 While rst=1 the next state SHALL be: busy=0, owner=0, pending=0, ptr=0, err=0.
REQ-031 In the reset cycle, outputs SHALL reflect the pre-reset state as combinational functions; from the first cycle after reset all outputs are 0 until stimulus arrives.
REQ-032 Reset mid-operation SHALL drop all outstanding operations; a later apu_rvalid_i for a dropped operation is treated per REQ-026.

Verification (NB_CORES=4, NB_APUS=2)
REQ-033 After reset, drive req_i=1111 and apu_gnt_i=11 -> gnt_o=0011, routing_addr_o[0]=0, routing_addr_o[1]=1; next cycle apu_busy_o=11 and ptr=2.
REQ-034 With both APUs busy, drive req_i=1100 -> apu_req_o=00 and gnt_o=0000; then drive apu_rvalid_i=10 -> core_rvalid_o=0010; next cycle req_i=1100 -> gnt_o=0100 with routing_addr_o[2]=1.
REQ-035 Wrap-around: with ptr=3, both APUs free and req_i=1001 -> core3 gets APU0 and core0 gets APU1, gnt_o=1001; ptr becomes 1.
REQ-036 Stall: core0 assigned to APU0 with apu_gnt_i[0]=0 -> apu_req_o[0]=1 and gnt_o[0]=0, with no busy change; raising apu_gnt_i[0] later -> grant, and busy[0] is set the following cycle.
REQ-037 Error and reset: apu_rvalid_i=01 while APU0 is idle -> core_rvalid_o=0000 and err_o=1 for exactly one cycle; assert rst with both APUs busy -> apu_busy_o=00 next cycle, and a subsequent apu_rvalid_i raises err_o.
